// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage pipelined accumulator ALU with valid/ready handshakes.
//
// Stage 1 captures the operands and opcode. Stage 2 computes the result and
// registers it together with the flags. One advance enable (adv) moves both
// stages at once, so a stalled consumer freezes the whole pipeline and no
// operation is lost.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operation present on accum/data/opcode
//   in_ready  : pipeline accepts an operation this cycle
//   accum     : accumulator operand (WIDTH bits)
//   data      : data operand (WIDTH bits)
//   opcode    : operation select (typedefs::opcode_t)
//   out_valid : out and flags are valid
//   out_ready : consumer takes the result this cycle
//   out       : result (WIDTH bits)
//   zero      : accum operand of this op was all-zero
//   carry     : carry-out of ADD, 0 otherwise
//   ovf       : signed overflow of ADD, 0 otherwise
//   neg       : MSB of out

package typedefs;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;
endpackage

module alu_pipe
  import typedefs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  input  opcode_t          opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             neg
);

  logic                    adv;
  logic                    vld_p1;
  logic signed [WIDTH-1:0] accum_p1;
  logic signed [WIDTH-1:0] data_p1;
  opcode_t                 opcode_p1;
  logic        [WIDTH-1:0] res_p1;
  logic                    carry_p1;
  logic                    ovf_p1;

  // Returns {carry, ovf, result}. Anything that is not a data-producing op
  // passes accum through, so an unexpected opcode still yields a defined value.
  function automatic logic [WIDTH+1:0] alu_calc(
    input opcode_t                 op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    sum = {1'b0, a} + {1'b0, b};
    r   = a;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      ADD: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      AND:     r = a & b;
      XOR:     r = a ^ b;
      LDA:     r = b;
      default: r = a;
    endcase
    return {c, v, r};
  endfunction

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;

  assign {carry_p1, ovf_p1, res_p1} = alu_calc(opcode_p1, accum_p1, data_p1);

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (adv) begin
      accum_p1  <= accum;
      data_p1   <= data;
      opcode_p1 <= opcode;
    end
  end

  // ---- stage 2: result and flag registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      neg       <= 1'b0;
    end else if (adv) begin
      vld_p1    <= in_valid;
      out_valid <= vld_p1;
      // A bubble clears out_valid but leaves the last result visible.
      if (vld_p1) begin
        out   <= res_p1;
        zero  <= (accum_p1 == '0);
        carry <= carry_p1;
        ovf   <= ovf_p1;
        neg   <= res_p1[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- self-checking bench for alu_pipe at WIDTH 8, 16 and 4.
module tb_alu_pipe;
  import typedefs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ov8, or8, z8, c8, v8, n8;
  logic [7:0] a8, d8, o8;
  opcode_t    op8;

  logic        iv16, ir16, ov16, or16, z16, c16, v16, n16;
  logic [15:0] a16, d16, o16;
  opcode_t     op16;

  logic       iv4, ir4, ov4, or4, z4, c4, v4, n4;
  logic [3:0] a4, d4, o4;
  opcode_t    op4;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .accum(a8), .data(d8),
    .opcode(op8), .out_valid(ov8), .out_ready(or8), .out(o8), .zero(z8),
    .carry(c8), .ovf(v8), .neg(n8));

  alu_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .accum(a16), .data(d16),
    .opcode(op16), .out_valid(ov16), .out_ready(or16), .out(o16), .zero(z16),
    .carry(c16), .ovf(v16), .neg(n16));

  alu_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .accum(a4), .data(d4),
    .opcode(op4), .out_valid(ov4), .out_ready(or4), .out(o4), .zero(z4),
    .carry(c4), .ovf(v4), .neg(n4));

  typedef struct {
    longint res;
    bit     z, c, v, n;
  } exp_t;

  // Reference: integer arithmetic on the operand values, signed overflow
  // judged by whether the true signed sum fits in w bits.
  function automatic exp_t model(int w, int op, longint a, longint b);
    exp_t   e;
    longint one  = 1;
    longint m    = (one << w) - 1;
    longint half = one << (w - 1);
    longint s, sa, sb;
    e.c = 0;
    e.v = 0;
    e.z = (a == 0);
    case (op)
      2: begin
        s     = a + b;
        e.res = s & m;
        e.c   = (s > m);
        sa    = (a >= half) ? a - (m + 1) : a;
        sb    = (b >= half) ? b - (m + 1) : b;
        e.v   = (sa + sb > half - 1) || (sa + sb < -half);
      end
      3:       e.res = a & b;
      4:       e.res = a ^ b;
      5:       e.res = b;
      default: e.res = a;
    endcase
    e.n = ((e.res >> (w - 1)) & 1) != 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv8 = 0; or8 = 1; a8 = '0; d8 = '0; op8 = HLT;
    iv16 = 0; or16 = 1; a16 = '0; d16 = '0; op16 = HLT;
    iv4 = 0; or4 = 1; a4 = '0; d4 = '0; op4 = HLT;
    repeat (2) step();
    n_checks++;
    if ({ir8, ov8, o8, z8, c8, v8, n8} !== 14'b0) begin
      n_fail++;
      $display("FAIL reset_u8: got %b required 0", {ir8, ov8, o8, z8, c8, v8, n8});
    end
    n_checks++;
    if ({ir16, ov16, o16, z16, c16, v16, n16} !== 22'b0) begin
      n_fail++;
      $display("FAIL reset_u16: got %b required 0", {ir16, ov16, o16, z16, c16, v16, n16});
    end
    n_checks++;
    if ({ir4, ov4, o4, z4, c4, v4, n4} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_u4: got %b required 0", {ir4, ov4, o4, z4, c4, v4, n4});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (ir8 !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_after_reset: got %b required 1", ir8);
    end
  endtask

  task automatic test_add_ovf();
    iv8 = 1; op8 = ADD; a8 = 8'h7F; d8 = 8'h01; or8 = 1;
    step();
    iv8 = 0;
    n_checks++;
    if (ov8 !== 1'b0) begin
      n_fail++;
      $display("FAIL add_latency_early: out_valid got %b required 0", ov8);
    end
    step();
    n_checks++;
    if ({ov8, o8, z8, c8, v8, n8} !== {1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL add_ovf: got v=%b out=%h z=%b c=%b o=%b n=%b required v=1 out=80 z=0 c=0 o=1 n=1",
               ov8, o8, z8, c8, v8, n8);
    end
    step();
  endtask

  task automatic test_carry_zero();
    iv8 = 1; op8 = ADD; a8 = 8'hFF; d8 = 8'h01;
    step();
    op8 = STO; a8 = 8'h00; d8 = 8'h33;
    step();
    iv8 = 0;
    n_checks++;
    if ({ov8, o8, z8, c8, v8, n8} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_carry: got v=%b out=%h z=%b c=%b o=%b n=%b required v=1 out=00 z=0 c=1 o=0 n=0",
               ov8, o8, z8, c8, v8, n8);
    end
    step();
    n_checks++;
    if ({ov8, o8, z8, c8, v8, n8} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sto_zero: got v=%b out=%h z=%b c=%b o=%b n=%b required v=1 out=00 z=1 c=0 o=0 n=0",
               ov8, o8, z8, c8, v8, n8);
    end
    step();
  endtask

  task automatic test_back_to_back();
    opcode_t    bop  [4] = '{ADD, AND, XOR, LDA};
    logic [7:0] ba   [4] = '{8'h03, 8'hF0, 8'hAA, 8'h91};
    logic [7:0] bd   [4] = '{8'h04, 8'h3C, 8'hFF, 8'h5A};
    logic [7:0] bexp [4] = '{8'h07, 8'h30, 8'h55, 8'h5A};
    or8 = 1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        iv8 = 1; op8 = bop[i]; a8 = ba[i]; d8 = bd[i];
      end else begin
        iv8 = 0;
      end
      step();
      if (i >= 1 && i <= 4) begin
        n_checks++;
        if ({ov8, o8} !== {1'b1, bexp[i-1]}) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: got v=%b out=%h required v=1 out=%h", i - 1, ov8, o8, bexp[i-1]);
        end
      end
      if (i == 5) begin
        n_checks++;
        if ({ov8, o8} !== {1'b0, 8'h5A}) begin
          n_fail++;
          $display("FAIL bubble_hold: got v=%b out=%h required v=0 out=5a", ov8, o8);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    opcode_t    pop  [3] = '{ADD, XOR, AND};
    logic [7:0] pa   [3] = '{8'h10, 8'h0F, 8'h3C};
    logic [7:0] pd   [3] = '{8'h20, 8'hFF, 8'h0F};
    logic [7:0] pexp [3] = '{8'h30, 8'hF0, 8'h0C};
    int iss = 0;
    int got = 0;
    for (int k = 0; k < 12; k++) begin
      or8 = !(k >= 2 && k <= 5);
      if (iss < 3) begin
        iv8 = 1; op8 = pop[iss]; a8 = pa[iss]; d8 = pd[iss];
      end else begin
        iv8 = 0;
      end
      #1;
      if (k >= 2 && k <= 5) begin
        n_checks++;
        if ({ir8, ov8, o8} !== {1'b0, 1'b1, pexp[0]}) begin
          n_fail++;
          $display("FAIL stall[%0d]: got in_ready=%b v=%b out=%h required in_ready=0 v=1 out=%h",
                   k, ir8, ov8, o8, pexp[0]);
        end
      end
      if (iv8 && ir8) iss++;
      if (ov8 && or8) begin
        n_checks++;
        if (got >= 3) begin
          n_fail++;
          $display("FAIL bp_extra: got out=%h required no further result", o8);
        end else if (o8 !== pexp[got]) begin
          n_fail++;
          $display("FAIL bp_order[%0d]: got %h required %h", got, o8, pexp[got]);
        end
        got++;
      end
      step();
    end
    n_checks++;
    if (got != 3 || iss != 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results %0d issued required 3 and 3", got, iss);
    end
  endtask

  task automatic test_reset_mid();
    or8 = 1;
    iv8 = 1; op8 = ADD; a8 = 8'h01; d8 = 8'h01;
    step();
    op8 = XOR; a8 = 8'h55; d8 = 8'h0F;
    rst = 1;
    #1;
    n_checks++;
    if (ir8 !== 1'b0) begin
      n_fail++;
      $display("FAIL in_ready_in_reset: got %b required 0", ir8);
    end
    step();
    rst = 0;
    iv8 = 0;
    n_checks++;
    if ({ov8, o8, z8, c8, v8, n8} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b required 0", {ov8, o8, z8, c8, v8, n8});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (ov8 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_leak[%0d]: out_valid got %b out=%h required 0", i, ov8, o8);
      end
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    for (int k = 0; k < 320; k++) begin
      if (k < 300) begin
        iv8 = ($urandom % 4) != 0;
        or8 = ($urandom % 4) != 0;
        a8  = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
        d8  = 8'($urandom);
        op8 = opcode_t'($urandom_range(0, 7));
      end else begin
        iv8 = 0;
        or8 = 1;
      end
      #1;
      n_checks++;
      if (ir8 !== (!ov8 || or8)) begin
        n_fail++;
        $display("FAIL rnd_in_ready[%0d]: got %b required %b", k, ir8, (!ov8 || or8));
      end
      if (iv8 && ir8) q.push_back(model(8, int'(op8), longint'(a8), longint'(d8)));
      if (ov8 && or8) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra[%0d]: got out=%h required no result", k, o8);
        end else begin
          e = q.pop_front();
          if ({o8, z8, c8, v8, n8} !== {e.res[7:0], e.z, e.c, e.v, e.n}) begin
            n_fail++;
            $display("FAIL rnd_result[%0d]: got out=%h z=%b c=%b o=%b n=%b required out=%h z=%b c=%b o=%b n=%b",
                     k, o8, z8, c8, v8, n8, e.res[7:0], e.z, e.c, e.v, e.n);
          end
        end
      end
      step();
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_lost: got %0d results outstanding required 0", q.size());
    end
  endtask

  task automatic test_param();
    exp_t e;
    iv16 = 1; op16 = ADD; a16 = 16'h8000; d16 = 16'h8000;
    iv4 = 1; op4 = XOR; a4 = 4'hA; d4 = 4'h5;
    step();
    iv16 = 0; iv4 = 0;
    step();
    n_checks++;
    if ({ov16, o16, z16, c16, v16, n16} !== {1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL w16_add: got v=%b out=%h z=%b c=%b o=%b n=%b required v=1 out=0000 z=0 c=1 o=1 n=0",
               ov16, o16, z16, c16, v16, n16);
    end
    n_checks++;
    if ({ov4, o4, n4, c4, v4} !== {1'b1, 4'hF, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL w4_xor: got v=%b out=%h n=%b c=%b o=%b required v=1 out=f n=1 c=0 o=0",
               ov4, o4, n4, c4, v4);
    end
    for (int j = 0; j < 6; j++) begin
      iv16 = 1; op16 = opcode_t'($urandom_range(0, 7)); a16 = 16'($urandom); d16 = 16'($urandom);
      step();
      iv16 = 0;
      step();
      e = model(16, int'(op16), longint'(a16), longint'(d16));
      n_checks++;
      if ({ov16, o16, z16, c16, v16, n16} !== {1'b1, e.res[15:0], e.z, e.c, e.v, e.n}) begin
        n_fail++;
        $display("FAIL w16_rnd[%0d]: got out=%h c=%b o=%b required out=%h c=%b o=%b",
                 j, o16, c16, v16, e.res[15:0], e.c, e.v);
      end
      iv4 = 1; op4 = opcode_t'($urandom_range(0, 7)); a4 = 4'($urandom); d4 = 4'($urandom);
      step();
      iv4 = 0;
      step();
      e = model(4, int'(op4), longint'(a4), longint'(d4));
      n_checks++;
      if ({ov4, o4, z4, c4, v4, n4} !== {1'b1, e.res[3:0], e.z, e.c, e.v, e.n}) begin
        n_fail++;
        $display("FAIL w4_rnd[%0d]: got out=%h c=%b o=%b required out=%h c=%b o=%b",
                 j, o4, c4, v4, e.res[3:0], e.c, e.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_carry_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational accumulator ALU.
- Executes the `typedefs::opcode_t` operation set (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP) on WIDTH-bit operands.
- Two register stages with valid/ready handshakes on input and output, plus carry/overflow/negative flags.
- Sits between the CPU controller and the accumulator register; back-pressure lets a slow consumer stall the datapath without losing operations.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 4 to 32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation present on accum/data/opcode.
- in_ready  output  1  pipeline accepts an operation this cycle.
- accum  input  WIDTH  accumulator operand.
- data  input  WIDTH  data operand.
- opcode  input  opcode_t  operation select.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  WIDTH  result.
- zero  output  1  accum operand of this op was all-zero (used by SKZ).
- carry  output  1  carry-out of ADD; 0 for all other ops.
- ovf  output  1  signed overflow of ADD; 0 for all other ops.
- neg  output  1  MSB of out.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk.
  - While rst=1 at an edge: both stage valids cleared; out, zero, carry, ovf, neg all 0; out_valid=0.
  - Reset mid-operation discards every in-flight op with no partial output.
  - in_ready is 0 while rst is asserted.
- Pipeline has a global advance enable: adv = !out_valid || out_ready; in_ready = adv && !rst.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1 (on adv):
  - Registers accum, data and opcode.
  - s1_valid <= in_valid.
  - A cycle without an input transfer enters a bubble (s1_valid=0).
- Stage 2 (on adv):
  - Computes the result from the stage-1 registers and registers out and the flags.
  - out_valid <= s1_valid.
- Latency: 2 cycles from input transfer to out_valid, with no stalls. Throughput: 1 op/cycle while out_ready=1.
- Stall: when out_valid && !out_ready, both stages hold, and out and the flags stay stable until transfer. Bubbles are not squeezed during a stall; this is accepted.
- Operations (WIDTH-bit, wrap-around arithmetic):
  - ADD: out = accum + data (low WIDTH bits); carry = bit WIDTH of the (WIDTH+1)-bit sum; ovf = (accum[MSB]==data[MSB]) && (out[MSB]!=accum[MSB]).
  - AND: out = accum & data.
  - XOR: out = accum ^ data.
  - LDA: out = data.
  - HLT, SKZ, JMP, STO: out = accum.
  - For every op except ADD: carry = 0 and ovf = 0.
- Flag rules:
  - zero = (stage-1 accum == 0), registered alongside out.
  - neg = out[WIDTH-1].
- Any opcode value outside the enum: out = accum, all flags from that rule set. The output is never X.
- Simultaneous input and output transfer in one cycle is legal and sustains full throughput.
- A bubble entering stage 2 clears out_valid but leaves out and the flags holding their previous value.
- in_valid with in_ready=0: the op is not taken. The source must hold it; hold is not checked.

Test Plan:
- Reset then ADD: rst 2 cycles, then ADD accum=8'h7F data=8'h01, out_ready=1 -> out_valid exactly 2 cycles later; out=8'h80, ovf=1, carry=0, neg=1, zero=0.
- Carry and zero: ADD accum=8'hFF data=8'h01 -> out=8'h00, carry=1, ovf=0. Then STO accum=8'h00 -> out=8'h00, zero=1.
- Back-to-back ops with out_ready=1: ADD(3,4), AND(8'hF0,8'h3C), XOR(8'hAA,8'hFF), LDA(x,8'h5A) on consecutive cycles -> results 8'h07, 8'h30, 8'h55, 8'h5A on 4 consecutive cycles, no bubbles.
- Back-pressure: 3 ops issued, out_ready=0 from the cycle the first result appears, for 4 cycles:
  - in_ready=0 throughout the stall;
  - out holds the first result stable;
  - on release, all 3 results arrive in order with none lost or duplicated.
- Reset mid-operation: 2 ops in flight, rst=1 for 1 cycle -> next cycle out_valid=0 and all outputs 0; neither op ever appears at the output.
- Parametrisation: WIDTH=16, ADD 16'h8000+16'h8000 -> out=16'h0000, carry=1, ovf=1, zero=0. WIDTH=4, XOR 4'hA^4'h5 -> out=4'hF, neg=1.
